// File: rtl/instruction_fetch_memory.sv
// Purpose : instruction store that is loaded by a word stream, then serves indexed instruction reads.
// Latency : reads return one cycle after rd_en; load words are written in the cycle they are accepted.
// Backpressure: load_ready is high only while loading; reads are never stalled (one per cycle).
//
// Ports:
//   clock, reset                 - single rising-edge clock, synchronous active-high reset
//   load_start                   - begin a new program load (ignored while a load is running)
//   load_valid/load_ready        - handshake for load_data; load_last marks the final word
//   load_data                    - word written at the current load pointer
//   load_done                    - one-cycle pulse in the first cycle after the final load word
//   load_count                   - number of words written by the most recent load
//   rd_en, endereco              - read request and address
//   instrucao, rd_valid, rd_error- registered read response; errored reads return NOP_WORD
module instruction_fetch_memory #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic                  load_last,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [ADDR_WIDTH:0]   load_count,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] endereco,
  output logic [DATA_WIDTH-1:0] instrucao,
  output logic                  rd_valid,
  output logic                  rd_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  enter_load;
  logic                  xfer;
  logic                  xfer_final;
  logic                  rd_hit;

  // Next-state and load handshake decode.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    enter_load = 1'b0;
    xfer       = 1'b0;
    xfer_final = 1'b0;
    case (state)
      IDLE, READY: begin
        if (load_start) begin
          state_nxt  = LOAD;
          enter_load = 1'b1;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        xfer       = load_valid;
        // A transfer into the last address ends the load even without
        // load_last, so the pointer never wraps onto word 0.
        xfer_final = load_valid && (load_last || (&wr_ptr));
        if (xfer_final) begin
          state_nxt = READY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only words written by the current load are readable; anything at or
  // beyond load_count is stale and reported as an error.
  assign rd_hit = (state == READY) && ({1'b0, endereco} < load_count);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      load_count <= '0;
      load_done  <= 1'b0;
    end else begin
      load_done <= xfer_final;
      if (enter_load) begin
        wr_ptr     <= '0;
        load_count <= '0;
      end else if (xfer) begin
        wr_ptr     <= wr_ptr + 1'b1;
        load_count <= load_count + 1'b1;
      end
    end
  end

  // Storage is deliberately never cleared: reset only blocks the write.
  always_ff @(posedge clock) begin
    if (xfer && !reset) begin
      mem[wr_ptr] <= load_data;
    end
  end

  // Read response; instrucao holds its last value on idle cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid  <= 1'b0;
      rd_error  <= 1'b0;
      instrucao <= NOP_WORD;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_error  <= !rd_hit;
        instrucao <= rd_hit ? mem[endereco] : NOP_WORD;
      end else begin
        rd_error  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Bench for instruction_fetch_memory: directed load/read scenarios followed by
// random traffic, checked against a word-array reference model via a response queue.
module tb_instruction_fetch_memory;

  localparam int DEPTH = 256;
  localparam logic [7:0] NOP = 8'h00;

  logic       clock;
  logic       reset;
  logic       load_start;
  logic       load_valid;
  logic       load_last;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  logic [8:0] load_count;
  logic       rd_en;
  logic [7:0] endereco;
  logic [7:0] instrucao;
  logic       rd_valid;
  logic       rd_error;

  instruction_fetch_memory dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_last  (load_last),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .load_count (load_count),
    .rd_en      (rd_en),
    .endereco   (endereco),
    .instrucao  (instrucao),
    .rd_valid   (rd_valid),
    .rd_error   (rd_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected read response for each clock edge, in edge order.
  typedef struct packed {
    logic       vld;
    logic       err;
    logic [7:0] dat;
  } rsp_t;
  rsp_t exp_q[$];

  // Reference model: mode 0 = idle, 1 = loading, 2 = ready.
  int         m_mode = 0;
  int         m_cnt  = 0;
  logic       m_done = 1'b0;
  logic [7:0] m_hold = NOP;
  logic [7:0] m_mem [DEPTH];

  // Drive one cycle of inputs at the falling edge; first confirm the
  // load-side outputs produced by the previous edge against the model.
  task automatic drive(input logic rst, input logic ls, input logic lv, input logic ll,
                       input logic [7:0] ld, input logic re, input logic [7:0] a);
    rsp_t e;
    @(negedge clock);
    chk("load_count", {23'd0, load_count}, m_cnt);
    chk("load_done", {31'd0, load_done}, {31'd0, m_done});
    chk("load_ready", {31'd0, load_ready}, (m_mode == 1) ? 1 : 0);

    reset      = rst;
    load_start = ls;
    load_valid = lv;
    load_last  = ll;
    load_data  = ld;
    rd_en      = re;
    endereco   = a;

    if (rst) begin
      e.vld = 1'b0; e.err = 1'b0; e.dat = NOP;
      m_hold = NOP;
    end else if (re) begin
      e.vld = 1'b1;
      if (m_mode == 2 && int'(a) < m_cnt) begin
        e.err = 1'b0; e.dat = m_mem[a];
      end else begin
        e.err = 1'b1; e.dat = NOP;
      end
      m_hold = e.dat;
    end else begin
      e.vld = 1'b0; e.err = 1'b0; e.dat = m_hold;
    end
    exp_q.push_back(e);

    if (rst) begin
      m_mode = 0; m_cnt = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_mode != 1) begin
        if (ls) begin
          m_mode = 1; m_cnt = 0;
        end
      end else if (lv) begin
        m_mem[m_cnt] = ld;
        m_cnt++;
        if (ll || m_cnt == DEPTH) begin
          m_mode = 2; m_done = 1'b1;
        end
      end
    end
  endtask

  // Monitor: compare each edge's read response with the queued expectation.
  rsp_t mon_e;
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, mon_e.vld});
      chk("rd_error", {31'd0, rd_error}, {31'd0, mon_e.err});
      chk("instrucao", {24'd0, instrucao}, {24'd0, mon_e.dat});
    end
  end

  initial begin
    int n;
    reset = 1'b1; load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    load_data = '0; rd_en = 1'b0; endereco = '0;

    // Reset, with a read request that reset must override.
    drive(1, 0, 0, 0, 8'h00, 1, 8'h00);
    drive(1, 1, 1, 0, 8'h77, 1, 8'h00);
    // Read in IDLE.
    drive(0, 0, 0, 0, 8'h00, 1, 8'h00);

    // Three-word load; read of the address being written is an error.
    drive(0, 1, 0, 0, 8'h00, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h1C, 1, 8'h00);
    drive(0, 1, 0, 0, 8'h00, 1, 8'h02);
    drive(0, 0, 1, 0, 8'hE3, 0, 8'h00);
    drive(0, 0, 1, 1, 8'h00, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00, 1, 8'h01);
    chk("load3_done", {31'd0, load_done}, 1);
    chk("load3_count", {23'd0, load_count}, 3);
    drive(0, 0, 0, 0, 8'h00, 1, 8'h05);
    // Back-to-back reads 0..3 (3 is past the loaded range).
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 8'h00, 1, 8'(i));
    drive(0, 0, 0, 0, 8'h00, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00, 0, 8'h00);

    // Reset in the middle of a four-word load, then a one-word load.
    drive(0, 1, 0, 0, 8'h00, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h11, 0, 8'h00);
    drive(0, 0, 1, 0, 8'h22, 0, 8'h00);
    drive(1, 0, 1, 0, 8'h33, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00, 1, 8'h00);
    chk("abort_count", {23'd0, load_count}, 0);
    drive(0, 1, 0, 0, 8'h00, 0, 8'h00);
    drive(0, 0, 1, 1, 8'h5A, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00, 1, 8'h00);
    drive(0, 0, 0, 0, 8'h00, 1, 8'h01);

    // Full load of every address without load_last, with bubbles and ignored load_start.
    drive(0, 1, 0, 0, 8'h00, 0, 8'h00);
    n = 0;
    while (m_mode == 1 && n < 2000) begin
      drive(0, logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 4) != 0), 1'b0,
            8'($urandom), logic'($urandom_range(0, 2) == 0), 8'($urandom));
      n++;
    end
    chk("full_load_bounded", (m_mode == 2) ? 1 : 0, 1);
    drive(0, 0, 1, 0, 8'hFF, 1, 8'hFF);
    chk("full_count", {23'd0, load_count}, 256);
    drive(0, 0, 1, 0, 8'hFF, 1, 8'h00);
    chk("full_ready_low", {31'd0, load_ready}, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 8'h00, 1, 8'($urandom));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(logic'($urandom_range(0, 299) == 0), logic'($urandom_range(0, 39) == 0),
            logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 9) == 0),
            8'($urandom), logic'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)));
    end
    drive(0, 0, 0, 0, 8'h00, 0, 8'h00);

    repeat (3) @(posedge clock);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_memory.md
INSTRUCTION_FETCH_MEMORY -- requirements
Module: instruction_fetch_memory

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter NOP_WORD, default all-zero, word returned on any errored read.
REQ-004 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port load_start  input  1  request to begin a program load.
REQ-007 SHALL have port load_valid  input  1  load_data holds a valid word.
REQ-008 SHALL have port load_last  input  1  marks the final word of a load.
REQ-009 SHALL have port load_data  input  DATA_WIDTH  word to be written.
REQ-010 SHALL have port load_ready  output  1  block accepts a load word this cycle.
REQ-011 SHALL have port load_done  output  1  one-cycle pulse at load completion.
REQ-012 SHALL have port load_count  output  ADDR_WIDTH+1  words written by the most recent load.
REQ-013 SHALL have port rd_en  input  1  read request.
REQ-014 SHALL have port endereco  input  ADDR_WIDTH  read address.
REQ-015 SHALL have port instrucao  output  DATA_WIDTH  read data.
REQ-016 SHALL have port rd_valid  output  1  instrucao/rd_error valid this cycle.
REQ-017 SHALL have port rd_error  output  1  read was refused or out of the loaded range.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, READY.
REQ-019 SHALL go IDLE->LOAD or READY->LOAD on load_start; load_start in LOAD is ignored.
REQ-020 SHALL, on entering LOAD, clear the write pointer and load_count to 0.
REQ-021 SHALL assert load_ready only in LOAD, as a combinational function of state.
REQ-022 SHALL, on each load_valid&load_ready cycle, write load_data to MEM[pointer] and increment both pointer and load_count.
REQ-023 SHALL leave LOAD for READY after the transfer carrying load_last, or after the transfer to address DEPTH-1 (full); a pointer wrap to 0 is never written.
REQ-024 SHALL pulse load_done for exactly the one cycle after the final transfer, coincident with the first READY cycle.
REQ-025 SHALL retain in memory any words not overwritten by a load; the array is never cleared.
REQ-026 SHALL, for rd_en at cycle N in READY with endereco < load_count, present MEM[endereco] on instrucao with rd_valid=1, rd_error=0 at N+1 (1-cycle latency).
REQ-027 SHALL, for rd_en with endereco >= load_count, or with the FSM in IDLE/LOAD, present NOP_WORD, rd_valid=1, rd_error=1 at N+1.
REQ-028 SHALL, when rd_en=0, drive rd_valid=0 and rd_error=0 next cycle while holding instrucao at its previous value.
REQ-029 SHALL return, for a read and write to the same address in the same cycle, the error response of REQ-027, since the FSM is in LOAD.
REQ-030 SHALL sustain back-to-back reads, one per cycle, with no bubbles.

Reset
REQ-031 SHALL, on reset, set state=IDLE, pointer=0, load_count=0, load_done=0, rd_valid=0, rd_error=0, instrucao=NOP_WORD.
REQ-032 SHALL abort any load in progress on reset, with no load_done pulse; words already written remain in memory.
REQ-033 SHALL give reset priority over load_start, load_valid and rd_en in the same cycle.

Verification
REQ-034 SHALL cover load: load 3 words 0x1C,0xE3,0x00 with load_last on the 3rd -> load_count=3, load_done high 1 cycle, then read addr 1 -> instrucao=0xE3, rd_valid=1, rd_error=0 one cycle later.
REQ-035 SHALL cover out-of-range read: after the REQ-034 load, read addr 5 -> instrucao=NOP_WORD, rd_error=1.
REQ-036 SHALL cover full load: 256 words without load_last (ADDR_WIDTH=8) -> exit to READY after addr 255, load_count=256, load_ready=0 afterwards.
REQ-037 SHALL cover reads outside READY: rd_en in IDLE after reset and in LOAD -> rd_valid=1, rd_error=1, instrucao=NOP_WORD.
REQ-038 SHALL cover reset mid-load: reset after 2 of 4 words -> IDLE, load_count=0, no load_done; a new load of 1 word, then read addr 0 -> new word.
REQ-039 SHALL cover pipelined reads: rd_en for 4 consecutive cycles at addrs 0..3 -> 4 consecutive rd_valid cycles with matching data.
